// File: rtl/seven_seg_pkg.sv
// ----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment anode scanner:
//   phase_e           BLANK/DRIVE phase encoding of a digit slot
//   DEF_DIV           default clock cycles per digit slot
//   DEF_BLANK_CYCLES  default anti-ghosting blank cycles per slot
//   clog2()           ceiling log2, never less than 1 bit
// ----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    localparam int DEF_DIV          = 100000;
    localparam int DEF_BLANK_CYCLES = 16;

    // Minimum of 1 so that counters and indices always have a real bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// ----------------------------------------------------------------------------
// seven_seg_slot_timer
// Per-slot cycle counter and BLANK/DRIVE phase tracker for the anode scanner.
//
// cnt_q is a look-ahead pointer: it holds the in-slot cycle number that the
// registered outputs of the parent will show after the next enabled edge.
// phase_q is the phase belonging to cnt_q, so the parent can decode the next
// anode value straight from flops.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   enable_i      1 = advance, 0 = hold cnt and phase
//   slot_first_o  enabled edge that presents cycle 0 of a slot
//   slot_wrap_o   enabled edge that presents the last cycle of a slot
//   phase_o       phase of the cycle presented on the next enabled edge
//
// phase    | meaning
// ---------+-------------------------------------------------------------
// PH_BLANK | cnt < BLANK_CYCLES, all anodes forced inactive
// PH_DRIVE | BLANK_CYCLES <= cnt <= DIV-1, selected anode may be driven
// ----------------------------------------------------------------------------
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int DIV          = DEF_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   enable_i,
    output logic   slot_first_o,
    output logic   slot_wrap_o,
    output phase_e phase_o
);

    localparam int              CW       = clog2(DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam phase_e          PH_RST   = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;
    logic          blank_hit;

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // With no blanking the compare would be constant-false; keep it out.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_hit = 1'b0;
        end else begin : g_blank
            assign blank_hit = (cnt_d < CW'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        phase_d = phase_q;
        if (enable_i) begin
            phase_d = blank_hit ? PH_BLANK : PH_DRIVE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            phase_q <= PH_RST;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign slot_first_o = enable_i && (cnt_q == '0);
    assign slot_wrap_o  = enable_i && (cnt_q == CNT_LAST);
    assign phase_o      = phase_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Multiplexed seven-segment anode scanner with configurable digit count,
// dwell time, anti-ghosting blanking, per-digit mask, run/hold and anode
// polarity. All outputs are registered; next values are decoded from the
// look-ahead slot timer and idx_q.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      1 = scan runs, 0 = hold position with all anodes inactive
//   digit_en    per-digit enable mask, sampled at each slot boundary
//   anode       digit drive, at most one active
//   digit_sel   index of the digit whose slot is being shown
//   slot_start  one-cycle pulse on the first cycle of each slot
// ----------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DIV              = DEF_DIV,
    parameter int BLANK_CYCLES     = DEF_BLANK_CYCLES,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [clog2(NUM_DIGITS)-1:0]  digit_sel,
    output logic                          slot_start
);

    localparam int                    SW        = clog2(NUM_DIGITS);
    localparam logic [SW-1:0]         IDX_LAST  = SW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic   slot_first;
    logic   slot_wrap;
    phase_e phase;

    seven_seg_slot_timer #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .slot_first_o (slot_first),
        .slot_wrap_o  (slot_wrap),
        .phase_o      (phase)
    );

    // idx_q follows the look-ahead timer: after the last cycle of a slot is
    // presented it already points at the next digit, while sel_q still shows
    // the digit on the pins.
    logic [SW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] en_lat_q, en_lat_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic                  start_q, start_d;
    logic [NUM_DIGITS-1:0] onehot;

    always_comb begin
        idx_d    = idx_q;
        en_lat_d = en_lat_q;
        sel_d    = sel_q;
        start_d  = 1'b0;
        onehot   = '0;
        anode_d  = ANODE_OFF;
        if (enable) begin
            sel_d   = idx_q;
            start_d = slot_first;
            if ((phase == PH_DRIVE) && en_lat_q[idx_q]) begin
                onehot[idx_q] = 1'b1;
            end
            anode_d = onehot ^ ANODE_OFF;
            // The mask for the following slot is captured as the current one ends.
            if (slot_wrap) begin
                idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + SW'(1);
                en_lat_d = digit_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            en_lat_q <= '1;
            anode_q  <= ANODE_OFF;
            sel_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            en_lat_q <= en_lat_d;
            anode_q  <= anode_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
        end
    end

    assign anode      = anode_q;
    assign digit_sel  = sel_q;
    assign slot_start = start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
// Scoreboard bench: stimulus tasks push the expected pin values for the cycle
// after the next clock edge; a monitor pops and compares just after each edge.
// u_dut4: 4 digits, DIV=8, BLANK=2, active-low.
// u_dut6: 6 digits, DIV=8, no blanking, active-high.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    logic       clk;
    logic       rst4, en4, rst6, en6;
    logic [3:0] den4;
    logic [5:0] den6;
    logic [3:0] an4;
    logic [1:0] sel4;
    logic       st4;
    logic [5:0] an6;
    logic [2:0] sel6;
    logic       st6;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)
    ) u_dut4 (
        .clk(clk), .reset(rst4), .enable(en4), .digit_en(den4),
        .anode(an4), .digit_sel(sel4), .slot_start(st4)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(6), .DIV(8), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(0)
    ) u_dut6 (
        .clk(clk), .reset(rst6), .enable(en6), .digit_en(den6),
        .anode(an6), .digit_sel(sel6), .slot_start(st6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [7:0] anode;
        int         sel;
        bit         start;
        int         due;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    string tag_v = "init";
    logic [3:0] den_v;

    // Slot i: two blank cycles, then six cycles with anode i low.
    logic [3:0] exp_a [32] = '{
        4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
        4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD,
        4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB,
        4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7
    };

    // Monitor
    always @(posedge clk) begin
        exp_t       e;
        logic [7:0] act_an;
        int         act_sel;
        bit         act_st;
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                act_an  = {4'b0, an4};
                act_sel = int'(sel4);
                act_st  = st4;
            end else begin
                act_an  = {2'b0, an6};
                act_sel = int'(sel6);
                act_st  = st6;
            end
            n_cmp++;
            if (e.due != cyc || act_an !== e.anode || act_sel != e.sel || act_st !== e.start) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got anode=%b sel=%0d start=%0b, want anode=%b sel=%0d start=%0b",
                         e.tag, cyc, act_an, act_sel, act_st, e.anode, e.sel, e.start);
            end
        end
    end

    task automatic push(input int inst, input logic [7:0] ea, input int es, input bit est);
        exp_t e;
        e.inst  = inst;
        e.anode = ea;
        e.sel   = es;
        e.start = est;
        e.due   = cyc + 1;
        e.tag   = tag_v;
        sb.push_back(e);
    endtask

    task automatic tick4(input bit r, input bit e, input logic [3:0] d,
                         input logic [3:0] ea, input int es, input bit est);
        @(negedge clk);
        rst4 = r; en4 = e; den4 = d;
        rst6 = 1'b1; en6 = 1'b0; den6 = 6'h3F;
        push(0, {4'b0, ea}, es, est);
    endtask

    task automatic tick6(input bit r, input bit e, input logic [5:0] d,
                         input logic [7:0] ea, input int es, input bit est);
        @(negedge clk);
        rst6 = r; en6 = e; den6 = d;
        rst4 = 1'b1; en4 = 1'b0; den4 = 4'hF;
        push(1, ea, es, est);
    endtask

    // Cycles c0..c1 of slot i; 'dark' means the digit is masked this slot.
    task automatic run4(input int i, input int c0, input int c1, input bit dark,
                        input int chg_at = -1, input logic [3:0] new_den = 4'h0);
        logic [3:0] on;
        for (int c = c0; c <= c1; c++) begin
            if (c == chg_at) den_v = new_den;
            on = 4'b0001 << i;
            tick4(1'b0, 1'b1, den_v, (c < 2 || dark) ? 4'hF : ~on, i, c == 0);
        end
    endtask

    task automatic hold4(input int n, input int i);
        for (int k = 0; k < n; k++) begin
            tick4(1'b0, 1'b0, den_v, 4'hF, i, 1'b0);
        end
    endtask

    initial begin
        rst4 = 1'b1; en4 = 1'b0; den4 = 4'hF;
        rst6 = 1'b1; en6 = 1'b0; den6 = 6'h3F;
        den_v = 4'hF;

        // Reset held with enable high: reset wins.
        tag_v = "reset";
        tick4(1'b1, 1'b1, den_v, 4'hF, 0, 1'b0);
        tick4(1'b1, 1'b1, den_v, 4'hF, 0, 1'b0);

        tag_v = "round_a";
        for (int k = 0; k < 32; k++) begin
            tick4(1'b0, 1'b1, den_v, exp_a[k], k / 8, (k % 8) == 0);
        end

        // Mask 0111 applied early in the round: slot 3 dark for all 8 cycles.
        tag_v = "mask_0111";
        run4(0, 0, 7, 1'b0, 3, 4'h7);
        run4(1, 0, 7, 1'b0);
        run4(2, 0, 7, 1'b0);
        run4(3, 0, 7, 1'b1);

        // 1110 at idx 0 / cnt 3: digit 0 stays lit now, dark one round later.
        tag_v = "mask_1110";
        run4(0, 0, 7, 1'b0, 3, 4'hE);
        run4(1, 0, 7, 1'b0);
        run4(2, 0, 7, 1'b0);
        run4(3, 0, 7, 1'b0);
        tag_v = "mask_1110_next";
        run4(0, 0, 7, 1'b1, 3, 4'hF);
        run4(1, 0, 7, 1'b0);
        run4(2, 0, 7, 1'b0);
        run4(3, 0, 7, 1'b0);

        tag_v = "hold";
        run4(0, 0, 7, 1'b0);
        run4(1, 0, 3, 1'b0);
        hold4(5, 1);
        run4(1, 4, 7, 1'b0);
        run4(2, 0, 7, 1'b0);
        run4(3, 0, 7, 1'b0);

        tag_v = "reset_mid";
        run4(0, 0, 7, 1'b0);
        run4(1, 0, 7, 1'b0);
        run4(2, 0, 5, 1'b0);
        tick4(1'b1, 1'b1, den_v, 4'hF, 0, 1'b0);
        run4(0, 0, 7, 1'b0);
        run4(1, 0, 7, 1'b0);

        tag_v = "six_reset";
        tick6(1'b1, 1'b1, 6'h3F, 8'h00, 0, 1'b0);
        tag_v = "six_scan";
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) begin
                for (int c = 0; c < 8; c++) begin
                    tick6(1'b0, 1'b1, 6'h3F, 8'h01 << i, i, c == 0);
                end
            end
        end
        tag_v = "six_wrap";
        tick6(1'b0, 1'b1, 6'h3F, 8'h01, 0, 1'b1);
        tick6(1'b0, 1'b1, 6'h3F, 8'h01, 0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d entries left", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
